// File: rtl/cnt_step_monitor.sv
// cnt_step_monitor: classifies counter steps and queues irregular ones in a FWFT FIFO.
// Defining CNT_MON_LOG_ALL_EN pushes routine UP/DOWN steps as well.
module cnt_step_monitor #(
    parameter int W        = 10,
    parameter int DEPTH    = 4,
    parameter int UP_STEP  = 5,
    parameter int DN_STEP  = 9,
    parameter int WRAP_MIN = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] cnt_i,
    input  logic         cnt_vld_i,
    input  logic         ovf_clr_i,
    output logic         ev_valid_o,
    input  logic         ev_ready_i,
    output logic [2:0]   ev_kind_o,
    output logic [W:0]   ev_delta_o,
    output logic [W-1:0] ev_value_o,
    output logic         ovf_o,
    output logic [7:0]   drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [W:0] UP1  = (W+1)'(UP_STEP);
    localparam logic [W:0] UP2  = (W+1)'(2 * UP_STEP);
    localparam logic [W:0] DN1  = (W+1)'(-DN_STEP);
    localparam logic [W:0] DN2  = (W+1)'(-2 * DN_STEP);
    localparam logic [W:0] WMIN = (W+1)'(WRAP_MIN);
`ifdef CNT_MON_LOG_ALL_EN
    localparam bit LOG_ALL = 1'b1;
`else
    localparam bit LOG_ALL = 1'b0;
`endif

    logic [W-1:0] prev_q, prev_d;
    logic         prev_ok_q, prev_ok_d;
    logic [2:0]   kind_q [DEPTH];
    logic [2:0]   kind_d [DEPTH];
    logic [W:0]   dlt_q [DEPTH];
    logic [W:0]   dlt_d [DEPTH];
    logic [W-1:0] val_q [DEPTH];
    logic [W-1:0] val_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]  cnt_q, cnt_d;
    logic         ovf_q, ovf_d;
    logic [7:0]   drop_q, drop_d, drop_base;
    logic [W:0]   delta, mag;
    logic [2:0]   kind;
    logic         push, pop, full, drop, wr_en;

    always_comb begin
        delta     = {cnt_i[W-1], cnt_i} - {prev_q[W-1], prev_q};
        mag       = delta[W] ? -delta : delta;
        kind      = !prev_ok_q    ? 3'd0 :
                    delta == '0   ? 3'd5 :
                    delta == UP1  ? 3'd1 :
                    delta == DN1  ? 3'd2 :
                    delta == UP2  ? 3'd3 :
                    delta == DN2  ? 3'd4 :
                    mag >= WMIN   ? 3'd6 : 3'd7;
        push      = cnt_vld_i && (LOG_ALL || (kind != 3'd1 && kind != 3'd2));
        pop       = ev_valid_o && ev_ready_i;
        full      = cnt_q == (AW+1)'(DEPTH);
        drop      = push && full && !pop;
        wr_en     = push && !drop;
        kind_d    = kind_q;
        dlt_d     = dlt_q;
        val_d     = val_q;
        if (wr_en) begin
            kind_d[wr_q] = kind;
            dlt_d[wr_q]  = prev_ok_q ? delta : '0;
            val_d[wr_q]  = cnt_i;
        end
        wr_d      = wr_q + AW'(wr_en);
        rd_d      = rd_q + AW'(pop);
        cnt_d     = cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
        prev_d    = cnt_vld_i ? cnt_i : prev_q;
        prev_ok_d = prev_ok_q || cnt_vld_i;
        // a drop in the same cycle as a clear counts on top of the cleared value
        drop_base = ovf_clr_i ? 8'd0 : drop_q;
        drop_d    = (drop && drop_base != 8'hFF) ? drop_base + 8'd1 : drop_base;
        ovf_d     = drop || (ovf_q && !ovf_clr_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= '0;
            prev_ok_q <= 1'b0;
            kind_q    <= '{default: '0};
            dlt_q     <= '{default: '0};
            val_q     <= '{default: '0};
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            drop_q    <= '0;
        end else begin
            prev_q    <= prev_d;
            prev_ok_q <= prev_ok_d;
            kind_q    <= kind_d;
            dlt_q     <= dlt_d;
            val_q     <= val_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
        end
    end

    assign ev_valid_o = cnt_q != '0;
    assign ev_kind_o  = kind_q[rd_q];
    assign ev_delta_o = dlt_q[rd_q];
    assign ev_value_o = val_q[rd_q];
    assign ovf_o      = ovf_q;
    assign drop_cnt_o = drop_q;
endmodule

// File: doc/cnt_step_monitor.md
# cnt_step_monitor

Downstream observer for the signed up/down counter. Samples the counter value on a strobe, computes the step from the previous sample, classifies it into an event kind, and queues events in a small first-word-fall-through FIFO with a valid/ready output. Gives checkers and debug logic a cycle-decoupled record of irregular counter behaviour (skips, holds, wraps, anomalies).

## Interface
- W, 10: counter width (signed two's complement).
- DEPTH, 4: FIFO entries; power of two, >= 2.
- UP_STEP, 5: nominal increment magnitude.
- DN_STEP, 9: nominal decrement magnitude.
- WRAP_MIN, 256: minimum |delta| classified as WRAP.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cnt_i  in  W  signed counter value.
- cnt_vld_i  in  1  sample strobe; cnt_i is consumed on a rising edge where this is high.
- ovf_clr_i  in  1  clears ovf_o and drop_cnt_o.
- ev_valid_o  out  1  FIFO head valid.
- ev_ready_i  in  1  consumer accepts the head.
- ev_kind_o  out  3  event kind of the head.
- ev_delta_o  out  W+1  signed step of the head: cnt minus previous sample.
- ev_value_o  out  W  sampled cnt_i of the head.
- ovf_o  out  1  sticky: an event was dropped because the FIFO was full.
- drop_cnt_o  out  8  number of dropped events; saturates at 255.

## Operation
- Internal state: prev (W bits), prev_ok flag, FIFO storage, read/write pointers, occupancy count of width log2(DEPTH)+1.
- Delta = sign-extended cnt_i minus sign-extended prev, computed at W+1 bits; never truncated.
- Classification at each accepted sample, in priority order:
  - 0 START: prev_ok == 0; delta is reported as 0.
  - 5 HOLD: delta == 0.
  - 1 UP: delta == +UP_STEP.
  - 2 DOWN: delta == -DN_STEP.
  - 3 UP_SKIP: delta == +2*UP_STEP.
  - 4 DOWN_SKIP: delta == -2*DN_STEP.
  - 6 WRAP: |delta| >= WRAP_MIN.
  - 7 ANOMALY: anything else.
- Every accepted sample updates prev <= cnt_i and sets prev_ok <= 1, whether or not its event is pushed.
- Push filter: kinds UP and DOWN are routine and are not pushed. All other kinds are pushed (see Configuration).
- FIFO full and push requested with no pop in the same cycle: the event is dropped, ovf_o <= 1, and drop_cnt_o increments, saturating.
- Full with push and pop in the same cycle: both occur, nothing is dropped, and occupancy is unchanged.
- Empty with push and pop: a pop cannot occur because ev_valid_o = 0, so only the push takes effect.
- ovf_clr_i in the same cycle as a drop: the drop wins, leaving ovf_o = 1 and drop_cnt_o = 1.
- Reset values: ev_valid_o = 0, ev_kind_o = 0, ev_delta_o = 0, ev_value_o = 0, ovf_o = 0, drop_cnt_o = 0, prev_ok = 0, FIFO empty.
- Reset mid-operation discards all queued events. The first sample after reset is START.

## Timing
- Sample accepted at edge k: the event is written at edge k. If the FIFO was empty, ev_valid_o is high and ev_* carry the event in cycle k+1. Latency is one cycle.
- A pop occurs at an edge where ev_valid_o && ev_ready_i. The next entry, if any, appears in the following cycle.
- ev_* are held stable while ev_valid_o && !ev_ready_i.
- ev_* come directly from storage and the read pointer, with no combinational path from cnt_i or ev_ready_i.
- Throughput: one sample per cycle in, one event per cycle out.

## Configuration
- CNT_MON_LOG_ALL_EN defined: every accepted sample is pushed, including UP and DOWN. The FIFO then drops whenever the consumer falls behind.
- Undefined (default): only non-routine kinds (0, 3, 4, 5, 6, 7) are pushed.

## Test plan
- Reset, then samples -50, -45, -40 with ev_ready_i = 1 -> one event: START, value -50, delta 0. No further events; ovf_o = 0.
- After baseline -50, samples -16 then -6 -> UP_SKIP, delta +10, value -6. The -50 -> -16 step (+34) yields ANOMALY, delta +34.
- Samples 235 then -230 -> WRAP, delta -465, ev_delta_o = 11'h62F.
- ev_ready_i = 0 with 6 HOLD samples, DEPTH = 4 -> 4 queued, ovf_o = 1, drop_cnt_o = 2. Raising ev_ready_i drains exactly 4 in order. ovf_clr_i then returns ovf_o to 0.
- FIFO full, and a push coincides with a pop -> occupancy stays 4, no drop, and the new event appears last.
- rst asserted with 3 events queued -> ev_valid_o = 0 next cycle. The next sample of 100 yields START, value 100.
